// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control unit of the multicycle RV32I core. A Moore state machine
// steps each instruction through fetch / decode / execute / memory /
// writeback. It drives the ALU operation, the operand selects and every
// datapath enable. A small ALU decoder turns the internal 2-bit ALU op into
// the 3-bit ALUControl.
//
// Ports
//   clk        : core clock, rising edge
//   reset      : asynchronous, active-high reset
//   op         : instruction[6:0]
//   funct3     : instruction[14:12]
//   funct7b5   : instruction[30]
//   Zero       : ALU zero flag, used to resolve beq
//   PCWrite    : PC load enable (PCUpdate | Branch & Zero)
//   AdrSrc     : memory address select (0 PC, 1 ALUOut)
//   MemWrite   : data memory write enable
//   IRWrite    : instruction register load enable
//   RegWrite   : register file write enable
//   ResultSrc  : 00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    : 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    : 00 rs2, 01 ImmExt, 10 constant 4
//   ImmSrc     : 00 I, 01 S, 10 B, 11 J
//   ALUControl : 000 add, 001 sub, 010 and, 011 or, 100 sra,
//                101 slt, 110 xor, 111 sll
//   Illegal    : sticky illegal-opcode flag
//
// Build option
//   MULTICYCLE_CONTROL_TRAP_EN : when defined, an unknown opcode halts the
//   core in TRAP and raises Illegal until reset. When undefined, an unknown
//   opcode runs as a nop and Illegal is tied low.
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state;
  state_t     nextstate;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;

  // State register; reset drops any instruction in flight back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  // Next-state logic and Moore outputs. Everything defaults to the idle
  // value so each state only lists what it asserts.
  always_comb begin
    nextstate  = state;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    aluop      = 2'b00;
    case (state)
      FETCH: begin
        irwrite_s = 1'b1;
        pcupdate  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        nextstate = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_R:         nextstate = EXECUTER;
          OP_I:         nextstate = EXECUTEI;
          OP_BEQ:       nextstate = BEQ;
          OP_JAL:       nextstate = JAL;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          default:      nextstate = TRAP;
`else
          default:      nextstate = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextstate = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        nextstate = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        nextstate  = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        nextstate  = FETCH;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        aluop     = 2'b10;
        nextstate = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluop     = 2'b10;
        nextstate = ALUWB;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        nextstate  = FETCH;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        aluop     = 2'b01;
        branch    = 1'b1;
        nextstate = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcupdate  = 1'b1;
        nextstate = FETCH;
      end
      TRAP: begin
        nextstate = TRAP;
      end
      default: begin
        nextstate = FETCH;
      end
    endcase
  end

  // ALU decoder. Subtract only applies to R-type (op[5] set) with
  // funct7b5; addi with a stray bit 30 must still add. srl and sra share
  // the same ALU code.
  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b001:  ALUControl = 3'b111;
          3'b010:  ALUControl = 3'b101;
          3'b011:  ALUControl = 3'b101;
          3'b100:  ALUControl = 3'b110;
          3'b101:  ALUControl = 3'b100;
          3'b110:  ALUControl = 3'b011;
          default: ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by reset so nothing writes while reset is held, even
  // though the state register already sits in FETCH.
  assign PCWrite  = (pcupdate | (branch & Zero)) & ~reset;
  assign IRWrite  = irwrite_s  & ~reset;
  assign RegWrite = regwrite_s & ~reset;
  assign MemWrite = memwrite_s & ~reset;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic illegal_q;

  // Sticky flag raised on the DECODE->TRAP transition, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      illegal_q <= 1'b0;
    else if (state == DECODE && nextstate == TRAP)  illegal_q <= 1'b1;
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control. The stimulus side issues whole
// instructions, and a reference model pushes the output vector expected in
// every cycle of that instruction. A monitor pops one entry per falling
// edge and compares it with the DUT outputs. Directed cases come first,
// followed by random instructions.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } item_t;

  item_t sbq[$];
  int    assertions = 0;
  int    failures   = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
  //  ALUSrcB, ImmSrc, ALUControl, Illegal}
  function automatic logic [16:0] mk(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] aluc,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, aluc, ill};
  endfunction

  // Immediate format implied by each instruction.
  function automatic logic [1:0] refImm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation the instruction semantics require.
  function automatic logic [2:0] refAlu(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    case (f3)
      3'd0:    return (o == RT && f7) ? 3'b001 : 3'b000;  // sub / add
      3'd1:    return 3'b111;                             // sll
      3'd2:    return 3'b101;                             // slt
      3'd3:    return 3'b101;                             // sltu -> slt
      3'd4:    return 3'b110;                             // xor
      3'd5:    return 3'b100;                             // srl / sra
      3'd6:    return 3'b011;                             // or
      default: return 3'b010;                             // and
    endcase
  endfunction

  function automatic logic isLegal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
  endfunction

  // Monitor comparison for one popped scoreboard entry.
  task automatic checkOutput(input item_t it);
    logic [16:0] act;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, ALUControl, Illegal};
    assertions++;
    if (act !== it.exp) begin
      failures++;
      $display("[TB] FAIL %s: got %05h expected %05h", it.name, act, it.exp);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        checkOutput(it);
      end
    end
  end

  // Called 1 time unit after a rising edge. Holds reset for one cycle,
  // expecting FETCH-like selects with every enable off, then releases.
  task automatic doReset(input string tag, input logic [1:0] imm);
    item_t it;
    reset = 1'b1;
    it.name = {tag, ".reset"};
    it.exp  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    sbq.push_back(it);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one instruction starting in its FETCH cycle (1 time unit after a
  // rising edge). abortAfter >= 0 asserts reset after that many cycles.
  task automatic applyStimulus(input string tag, input logic [6:0] o,
                               input logic [2:0] f3, input logic f7,
                               input logic z, input int abortAfter);
    item_t       seq[$];
    item_t       it;
    logic [1:0]  imm;
    int          n;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    imm = refImm(o);
    it.name = {tag, ".fetch"};
    it.exp  = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    seq.push_back(it);
    it.name = {tag, ".decode"};
    it.exp  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    seq.push_back(it);
    if (o == LW || o == SW) begin
      it.name = {tag, ".memadr"};
      it.exp  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0);
      seq.push_back(it);
      if (o == LW) begin
        it.name = {tag, ".memread"};
        it.exp  = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
        seq.push_back(it);
        it.name = {tag, ".memwb"};
        it.exp  = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0);
        seq.push_back(it);
      end else begin
        it.name = {tag, ".memwrite"};
        it.exp  = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
        seq.push_back(it);
      end
    end else if (o == RT || o == IT) begin
      it.name = {tag, ".execute"};
      it.exp  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == RT) ? 2'b00 : 2'b01, imm,
                   refAlu(o, f3, f7), 0);
      seq.push_back(it);
      it.name = {tag, ".aluwb"};
      it.exp  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
      seq.push_back(it);
    end else if (o == BQ) begin
      it.name = {tag, ".beq"};
      it.exp  = mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 0);
      seq.push_back(it);
    end else if (o == JL) begin
      it.name = {tag, ".jal"};
      it.exp  = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0);
      seq.push_back(it);
    end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    else begin
      // Unknown opcode halts: the core must stay in TRAP with Illegal high.
      for (int k = 0; k < 12; k++) begin
        it.name = {tag, ".trap"};
        it.exp  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
        seq.push_back(it);
      end
    end
`endif
    n = (abortAfter >= 0 && abortAfter < seq.size()) ? abortAfter : seq.size();
    for (int k = 0; k < n; k++) sbq.push_back(seq[k]);
    repeat (n) @(posedge clk);
    #1;
    if (abortAfter >= 0) doReset(tag, imm);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    else if (!isLegal(o)) doReset(tag, imm);
`endif
  endtask

  initial begin : stimulus
    logic [6:0] ro;
    int         pick;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset check");
    doReset("init", 2'b00);

    applyStimulus("add",   RT, 3'b000, 1'b0, 1'b0, -1);
    applyStimulus("sub",   RT, 3'b000, 1'b1, 1'b1, -1);
    applyStimulus("addi7", IT, 3'b000, 1'b1, 1'b0, -1);
    applyStimulus("slli",  IT, 3'b001, 1'b0, 1'b0, -1);
    applyStimulus("srai",  IT, 3'b101, 1'b1, 1'b0, -1);
    applyStimulus("lw",    LW, 3'b010, 1'b0, 1'b0, -1);
    applyStimulus("sw",    SW, 3'b010, 1'b0, 1'b1, -1);
    applyStimulus("beqT",  BQ, 3'b000, 1'b0, 1'b1, -1);
    applyStimulus("beqF",  BQ, 3'b000, 1'b0, 1'b0, -1);
    applyStimulus("jal",   JL, 3'b101, 1'b1, 1'b1, -1);
    applyStimulus("swAbort", SW, 3'b010, 1'b0, 1'b0, 3);
    applyStimulus("afterAbort", RT, 3'b111, 1'b0, 1'b0, -1);
    applyStimulus("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
    applyStimulus("postIllegal", IT, 3'b110, 1'b0, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: ro = RT;
        1: ro = IT;
        2: ro = LW;
        3: ro = SW;
        4: ro = BQ;
        5: ro = JL;
        default: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          ro = RT;
`else
          ro = 7'($urandom);
          while (isLegal(ro)) ro = 7'($urandom);
`endif
        end
      endcase
      applyStimulus($sformatf("rnd%0d", i), ro, 3'($urandom), 1'($urandom),
                    1'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    assertions++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
